time_entry: RTL

Button-driven BCD editor for the MM:SS clock value. It is the writer side of the time path: it loads the running time and lets the user edit it one digit at a time. The cursor digit is exported as a one-hot mask so the display can blink it. Confirm delivers the edited value as a 16-bit BCD word together with a one-cycle finish strobe, which the timekeeper consumes.

---
 rtl/time_entry.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/time_entry.sv
// Button-driven BCD MM:SS editor with debounced inputs and one-hot cursor.
// Optional auto-repeat for up/down when TIME_ENTRY_AUTO_REPEAT_EN is defined.
module time_entry #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 32,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_confirm,
    input  logic [15:0] current_time,
    output logic [15:0] num_out,
    output logic [3:0]  which_seg_on,
    output logic        finish,
    output logic        busy
);

    localparam int NIN = 6;
    localparam int CW  = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LOAD, EDIT, COMMIT, DONE} state_t;

    // Bit order: 0 enable, 1 up, 2 down, 3 left, 4 right, 5 confirm.
    logic [NIN-1:0] raw, sync1, sync2, deb, press;
    logic [CW-1:0]  cnt [NIN];

    assign raw = {btn_confirm, btn_right, btn_left, btn_down, btn_up, enable};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            press <= '0;
            for (int unsigned i = 0; i < NIN; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < NIN; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i]   <= sync2[i];
                    press[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    logic en_level, en_rise, up_p, down_p;
    assign en_level = deb[0];
    assign en_rise  = press[0];

`ifdef TIME_ENTRY_AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX < 2) ? 1 : $clog2(RMAX + 1);

    logic [1:0]    rep, rphase;
    logic [RW-1:0] rcnt [2];

    // Channel 0 follows up, channel 1 follows down; first repeat after the
    // delay, then one per period until the debounced level drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep    <= '0;
            rphase <= '0;
            for (int unsigned j = 0; j < 2; j++) rcnt[j] <= '0;
        end else begin
            for (int unsigned j = 0; j < 2; j++) begin
                rep[j] <= 1'b0;
                if (!deb[1+j] || press[1+j]) begin
                    rcnt[j]   <= '0;
                    rphase[j] <= 1'b0;
                end else if (!rphase[j] && rcnt[j] == RW'(REPEAT_DELAY - 1)) begin
                    rep[j]    <= 1'b1;
                    rphase[j] <= 1'b1;
                    rcnt[j]   <= '0;
                end else if (rphase[j] && rcnt[j] == RW'(REPEAT_PERIOD - 1)) begin
                    rep[j]  <= 1'b1;
                    rcnt[j] <= '0;
                end else begin
                    rcnt[j] <= rcnt[j] + 1'b1;
                end
            end
        end
    end

    assign up_p   = press[1] | rep[0];
    assign down_p = press[2] | rep[1];
`else
    assign up_p   = press[1];
    assign down_p = press[2];
`endif

    logic act_confirm, act_up, act_down, act_left, act_right;
    assign act_confirm = press[5];
    assign act_up      = !act_confirm && up_p;
    assign act_down    = !act_confirm && !up_p && down_p;
    assign act_left    = !act_confirm && !up_p && !down_p && press[3];
    assign act_right   = !act_confirm && !up_p && !down_p && !press[3] && press[4];

    logic [15:0] clamped, edited;
    logic [3:0]  next_seg;

    always_comb begin
        clamped = '0;
        edited  = num_out;
        for (int unsigned k = 0; k < 4; k++) begin
            logic [3:0] lim, d;
            lim = (k == 1 || k == 3) ? 4'd5 : 4'd9;
            d   = current_time[4*k +: 4];
            clamped[4*k +: 4] = (d > lim) ? 4'd0 : d;
            d   = num_out[4*k +: 4];
            if (which_seg_on[k]) begin
                if (act_up)
                    edited[4*k +: 4] = (d >= lim) ? 4'd0 : d + 4'd1;
                else if (act_down)
                    edited[4*k +: 4] = (d == 4'd0) ? lim : d - 4'd1;
            end
        end
        next_seg = which_seg_on;
        if (act_left)
            next_seg = {which_seg_on[2:0], which_seg_on[3]};
        else if (act_right)
            next_seg = {which_seg_on[0], which_seg_on[3:1]};
    end

    state_t state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            num_out      <= '0;
            which_seg_on <= '0;
            finish       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            finish <= 1'b0;
            unique case (state)
                IDLE: begin
                    which_seg_on <= '0;
                    if (en_rise) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    num_out      <= clamped;
                    which_seg_on <= 4'b1000;
                    state        <= EDIT;
                end
                EDIT: begin
                    if (!en_level) begin
                        state        <= IDLE;
                        which_seg_on <= '0;
                        busy         <= 1'b0;
                    end else if (act_confirm) begin
                        state        <= COMMIT;
                        finish       <= 1'b1;
                        which_seg_on <= '0;
                        busy         <= 1'b0;
                    end else begin
                        num_out      <= edited;
                        which_seg_on <= next_seg;
                    end
                end
                COMMIT: state <= DONE;
                DONE: if (!en_level) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
